cam_alloc_ctrl: RTL and testbench



---
 rtl/cam_pkg.sv | 34 +++
 rtl/cam_alloc_ctrl_if.sv | 32 +++
 rtl/cam_alloc_ctrl_prienc.sv | 23 ++
 rtl/cam_alloc_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cam_alloc_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM request controller: op/status codes,
// controller state encoding and the slice-count helper.
package cam_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_MISS   = 2'd1,
        ST_FULL   = 2'd2,
        ST_EXISTS = 2'd3
    } cam_status_e;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_LKP      = 3'd2,
        S_LKP_WAIT = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_WR_HI    = 3'd5,
        S_WR_LO    = 3'd6,
        S_RSP      = 3'd7
    } cam_state_e;

    function automatic int slice_count(input int data_width, input int slice_width);
        return (data_width + slice_width - 1) / slice_width;
    endfunction

endpackage

// File: rtl/cam_alloc_ctrl_if.sv
// Request/response port of the CAM controller; master = scheduler side,
// slave = cam_alloc_ctrl.
interface cam_alloc_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 4
);
    import cam_pkg::*;
    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);

    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [DATA_WIDTH-1:0]  req_key;
    logic [SLICE_COUNT-1:0] req_mask;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_status;
    logic [1:0]             rsp_op;
    logic [ADDR_WIDTH-1:0]  rsp_addr;

    modport master (
        output req_valid, req_op, req_key, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_op, rsp_addr
    );

    modport slave (
        input  req_valid, req_op, req_key, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_op, rsp_addr
    );

endinterface

// File: rtl/cam_alloc_ctrl_prienc.sv
// LSB-first priority encoder; used to pick the lowest free CAM entry.
module priority_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 5
) (
    input  logic [WIDTH-1:0]     req_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 valid_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_WIDTH'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// Request-side controller for the shift-register CAM: lookup/insert/delete with
// lowest-free allocation. Macro CAM_ALLOC_DUP_CHECK_EN enables the duplicate search on INSERT.
module cam_alloc_ctrl
    import cam_pkg::*;
#(
    parameter int  DATA_WIDTH  = 64,
    parameter int  ADDR_WIDTH  = 5,
    parameter int  SLICE_WIDTH = 4,
    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    cam_alloc_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH:0]    entry_count,
    output logic [ADDR_WIDTH-1:0]  cam_write_addr,
    output logic [DATA_WIDTH-1:0]  cam_write_data,
    output logic                   cam_write_delete,
    output logic                   cam_write_enable,
    output logic [SLICE_COUNT-1:0] cam_select_mask,
    input  logic                   cam_write_busy,
    output logic [DATA_WIDTH-1:0]  cam_compare_data,
    input  logic                   cam_match,
    input  logic [ADDR_WIDTH-1:0]  cam_match_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    cam_state_e             state_q, state_d;
    cam_op_e                op_q, op_d;
    logic [DATA_WIDTH-1:0]  key_q, key_d;
    logic [SLICE_COUNT-1:0] mask_q, mask_d;
    logic [DEPTH-1:0]       bitmap_q, bitmap_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [1:0]             rsp_status_q, rsp_status_d;
    logic [1:0]             rsp_op_q, rsp_op_d;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q, rsp_addr_d;
    logic [ADDR_WIDTH:0]    count_q;
    logic [ADDR_WIDTH-1:0]  free_idx;
    logic                   free_vld;
    logic                   full;
    logic                   searching;

    priority_encoder #(
        .WIDTH     (DEPTH),
        .IDX_WIDTH (ADDR_WIDTH)
    ) u_free_sel (
        .req_i   (~bitmap_q),
        .idx_o   (free_idx),
        .valid_o (free_vld)
    );

    assign full = ~free_vld;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        mask_d       = mask_q;
        bitmap_d     = bitmap_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rsp_status_d = rsp_status_q;
        rsp_op_d     = rsp_op_q;
        rsp_addr_d   = rsp_addr_q;

        unique case (state_q)
            S_INIT: begin
                if (!cam_write_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = cam_op_e'(bus.req_op);
                    key_d    = bus.req_key;
                    mask_d   = bus.req_mask;
                    rsp_op_d = bus.req_op;
                    if (bus.req_op == OP_RSVD) begin
                        rsp_status_d = ST_EXISTS;
                        rsp_addr_d   = '0;
                        state_d      = S_RSP;
                    end
`ifndef CAM_ALLOC_DUP_CHECK_EN
                    else if (bus.req_op == OP_INSERT) begin
                        if (full) begin
                            rsp_status_d = ST_FULL;
                            rsp_addr_d   = '0;
                            state_d      = S_RSP;
                        end else begin
                            wr_addr_d = free_idx;
                            wr_data_d = bus.req_key;
                            state_d   = S_WR_ISSUE;
                        end
                    end
`endif
                    else begin
                        state_d = S_LKP;
                    end
                end
            end
            S_LKP: begin
                state_d = S_LKP_WAIT;
            end
            S_LKP_WAIT: begin
                state_d    = S_RSP;
                rsp_addr_d = '0;
                case (op_q)
                    OP_LOOKUP: begin
                        rsp_status_d = cam_match ? ST_OK : ST_MISS;
                        if (cam_match) rsp_addr_d = cam_match_addr;
                    end
`ifdef CAM_ALLOC_DUP_CHECK_EN
                    OP_INSERT: begin
                        if (cam_match) begin
                            rsp_status_d = ST_EXISTS;
                            rsp_addr_d   = cam_match_addr;
                        end else if (full) begin
                            rsp_status_d = ST_FULL;
                        end else begin
                            wr_addr_d = free_idx;
                            wr_data_d = key_q;
                            state_d   = S_WR_ISSUE;
                        end
                    end
`endif
                    OP_DELETE: begin
                        if (cam_match) begin
                            wr_addr_d = cam_match_addr;
                            wr_data_d = key_q;
                            state_d   = S_WR_ISSUE;
                        end else begin
                            rsp_status_d = ST_MISS;
                        end
                    end
                    default: rsp_status_d = ST_MISS;
                endcase
            end
            S_WR_ISSUE: begin
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                // Bitmap only changes once the CAM has finished shifting the entry in/out.
                if (!cam_write_busy) begin
                    bitmap_d[wr_addr_q] = (op_q != OP_DELETE);
                    rsp_status_d        = ST_OK;
                    rsp_addr_d          = wr_addr_q;
                    state_d             = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            mask_q       <= '1;
            bitmap_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rsp_status_q <= '0;
            rsp_op_q     <= '0;
            rsp_addr_q   <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            mask_q       <= mask_d;
            bitmap_q     <= bitmap_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_op_q     <= rsp_op_d;
            rsp_addr_q   <= rsp_addr_d;
            count_q      <= (ADDR_WIDTH + 1)'($countones(bitmap_q));
        end
    end

    assign searching        = (state_q == S_LKP) || (state_q == S_LKP_WAIT);
    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.rsp_valid    = (state_q == S_RSP);
    assign bus.rsp_status   = rsp_status_q;
    assign bus.rsp_op       = rsp_op_q;
    assign bus.rsp_addr     = rsp_addr_q;
    assign entry_count      = count_q;
    assign cam_write_enable = (state_q == S_WR_ISSUE);
    assign cam_write_delete = cam_write_enable && (op_q == OP_DELETE);
    assign cam_write_addr   = wr_addr_q;
    assign cam_write_data   = wr_data_q;
    assign cam_compare_data = searching ? key_q : '0;
    assign cam_select_mask  = (searching && op_q == OP_LOOKUP) ? mask_q : '1;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Randomised bench for cam_alloc_ctrl with a behavioural CAM and a key-table reference model.
module tb_cam_alloc_ctrl;

    localparam int DW     = 16;
    localparam int AW     = 3;
    localparam int SW     = 4;
    localparam int SC     = 4;
    localparam int DEPTH  = 8;
    localparam int WR_LAT = (1 << SW) + 2;

    logic clk;
    logic rst;
    logic [AW:0]   entry_count;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic [SC-1:0] cam_select_mask;
    logic          cam_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_hit;
    logic [AW-1:0] cam_hit_addr;

    cam_alloc_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) bus ();

    cam_alloc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .entry_count      (entry_count),
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_select_mask  (cam_select_mask),
        .cam_write_busy   (cam_busy),
        .cam_compare_data (cam_compare_data),
        .cam_match        (cam_hit),
        .cam_match_addr   (cam_hit_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] expand(input logic [SC-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int s = 0; s < SC; s++) r[s*SW +: SW] = {SW{m[s]}};
        return r;
    endfunction

    // Behavioural CAM: registered match, 2**SW busy cycles per write, init busy after reset.
    logic [DW-1:0] cam_mem [DEPTH];
    logic [DEPTH-1:0] cam_vld;
    int   cam_cnt;
    logic cam_init;
    logic cam_del;

    function automatic logic [AW:0] cam_search(input logic [DW-1:0] k, input logic [SC-1:0] m);
        for (int i = 0; i < DEPTH; i++)
            if (cam_vld[i] && (((cam_mem[i] ^ k) & expand(m)) == '0)) return {1'b1, AW'(i)};
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cam_busy <= 1'b1;
            cam_cnt  <= 12;
            cam_init <= 1'b1;
            cam_vld  <= '0;
            cam_hit  <= 1'b0;
            cam_hit_addr <= '0;
            cam_del  <= 1'b0;
        end else begin
            {cam_hit, cam_hit_addr} <= cam_search(cam_compare_data, cam_select_mask);
            if (cam_write_enable) begin
                cam_busy <= 1'b1;
                cam_cnt  <= (1 << SW) - 1;
                cam_init <= 1'b0;
                cam_del  <= cam_write_delete;
            end else if (cam_busy) begin
                if (cam_cnt == 0) begin
                    cam_busy <= 1'b0;
                    if (!cam_init) begin
                        cam_vld[cam_write_addr] <= !cam_del;
                        if (!cam_del) cam_mem[cam_write_addr] <= cam_write_data;
                    end
                end else begin
                    cam_cnt <= cam_cnt - 1;
                end
            end
        end
    end

    int we_count = 0;
    int rsp_hs   = 0;
    always @(posedge clk) begin
        if (!rst && cam_write_enable) we_count <= we_count + 1;
        if (!rst && bus.rsp_valid && bus.rsp_ready) rsp_hs <= rsp_hs + 1;
    end

    // Reference model: plain key table plus occupancy flags.
    logic [DW-1:0] m_key [DEPTH];
    bit            m_vld [DEPTH];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_vld[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int m_find(input logic [DW-1:0] k, input logic [SC-1:0] m);
        for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && ((m_key[i] & expand(m)) == (k & expand(m)))) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < DEPTH; i++) if (!m_vld[i]) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endtask

    task automatic predict(input logic [1:0] op, input logic [DW-1:0] key, input logic [SC-1:0] mask,
                           output logic [1:0] st, output logic [AW-1:0] addr, output bit addr_ok,
                           output int lat);
        int hit, fr;
        st = 2'd0; addr = '0; addr_ok = 1'b1; lat = 3;
        case (op)
            2'd0: begin
                hit = m_find(key, mask);
                if (hit >= 0) addr = AW'(hit);
                else begin st = 2'd1; addr_ok = 1'b0; end
            end
            2'd1: begin
                hit = m_find(key, '1);
                fr  = m_free();
`ifdef CAM_ALLOC_DUP_CHECK_EN
                if (hit >= 0) begin st = 2'd3; addr = AW'(hit); end
                else if (fr < 0) st = 2'd2;
                else begin addr = AW'(fr); lat = 3 + WR_LAT; m_key[fr] = key; m_vld[fr] = 1'b1; end
`else
                if (fr < 0) begin st = 2'd2; lat = 1; end
                else begin addr = AW'(fr); lat = 1 + WR_LAT; m_key[fr] = key; m_vld[fr] = 1'b1; end
`endif
            end
            2'd2: begin
                hit = m_find(key, '1);
                if (hit >= 0) begin addr = AW'(hit); lat = 3 + WR_LAT; m_vld[hit] = 1'b0; end
                else begin st = 2'd1; addr_ok = 1'b0; end
            end
            default: begin st = 2'd3; addr_ok = 1'b0; lat = 1; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [DW-1:0] key, input logic [SC-1:0] mask,
                          input int hold);
        logic [1:0]    e_st;
        logic [AW-1:0] e_addr;
        bit            e_addr_ok;
        int            e_lat, e_we, lat, w, we0;
        predict(op, key, mask, e_st, e_addr, e_addr_ok, e_lat);
        e_we = (e_st == 2'd0 && (op == 2'd1 || op == 2'd2)) ? 1 : 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_key   = key;
        bus.req_mask  = mask;
        bus.rsp_ready = (hold == 0);
        w = 0;
        while (!bus.req_ready && w < 200) begin tick(); w++; end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            return;
        end
        we0 = we_count;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_key   = DW'($urandom);
        bus.req_mask  = SC'($urandom);
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin tick(); lat++; end
        check("rsp_latency", lat, e_lat);
        check("rsp_status", bus.rsp_status, e_st);
        check("rsp_op", bus.rsp_op, op);
        if (e_addr_ok) check("rsp_addr", bus.rsp_addr, e_addr);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rsp_valid", bus.rsp_valid, 1'b1);
            check("hold_req_ready", bus.req_ready, 1'b0);
            check("hold_status", bus.rsp_status, e_st);
            if (e_addr_ok) check("hold_addr", bus.rsp_addr, e_addr);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("rsp_drop", bus.rsp_valid, 1'b0);
        check("entry_count", entry_count, m_count());
        check("write_pulses", we_count - we0, e_we);
    endtask

    task automatic do_reset(input bit check_regs);
        int w;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        if (check_regs) begin
            check("rst_rsp_status", bus.rsp_status, 2'd0);
            check("rst_rsp_op", bus.rsp_op, 2'd0);
            check("rst_rsp_addr", bus.rsp_addr, 0);
            check("rst_wr_addr", cam_write_addr, 0);
            check("rst_wr_data", cam_write_data, 0);
            check("rst_cmp_data", cam_compare_data, 0);
            check("rst_wr_delete", cam_write_delete, 1'b0);
        end
        w = 0;
        while (cam_busy && w < 100) begin
            check("init_req_ready", bus.req_ready, 1'b0);
            check("init_rsp_valid", bus.rsp_valid, 1'b0);
            tick();
            w++;
        end
        if (cam_busy) check("init_timeout", 32'd1, 32'd0);
        check("init_ready_lag", bus.req_ready, 1'b0);
        tick();
        check("idle_req_ready", bus.req_ready, 1'b1);
        check("rst_entry_count", entry_count, 0);
        check("rst_select_mask", cam_select_mask, 4'hF);
        check("rst_write_enable", cam_write_enable, 1'b0);
    endtask

    logic [DW-1:0] pool [10];

    initial begin
        int i, w, hs0, r;
        logic [DW-1:0] k;
        logic [1:0] op;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_key   = '0;
        bus.req_mask  = '0;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 10; j++) pool[j] = DW'(16'hA000 + j * 16'h0111);

        do_reset(1'b1);

        do_req(2'd1, 16'hBEEF, 4'hF, 0);
        do_req(2'd0, 16'hBEEF, 4'hF, 0);
        do_req(2'd0, 16'h1234, 4'hF, 0);
        do_req(2'd1, 16'hBEEF, 4'hF, 0);

        i = 0;
        while (m_count() < DEPTH && i < 20) begin
            do_req(2'd1, DW'(16'h1000 + i), 4'hF, 0);
            i++;
        end
        check("filled_count", entry_count, DEPTH);
        do_req(2'd1, 16'h7777, 4'hF, 0);

        do_req(2'd2, m_key[3], 4'hF, 0);
        do_req(2'd1, 16'h5555, 4'hF, 0);
        do_req(2'd2, 16'h9999, 4'hF, 0);
        do_req(2'd0, 16'hBE00, 4'hC, 10);
        do_req(2'd1, 16'hBEEF, 4'hF, 0);
        do_req(2'd3, 16'h0000, 4'hF, 0);

        // Reset while the CAM is mid-shift on a delete.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd2;
        bus.req_key   = m_key[2];
        bus.req_mask  = 4'hF;
        w = 0;
        while (!bus.req_ready && w < 50) begin tick(); w++; end
        tick();
        bus.req_valid = 1'b0;
        w = 0;
        while (!cam_busy && w < 50) begin tick(); w++; end
        check("wr_busy_seen", cam_busy, 1'b1);
        repeat (4) tick();
        hs0 = rsp_hs;
        do_reset(1'b0);
        check("rst_no_response", rsp_hs - hs0, 0);
        do_req(2'd0, 16'hBEEF, 4'hF, 0);

        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            k  = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 9)] : DW'($urandom);
            do_req(op, k, (op == 2'd0) ? SC'($urandom) : 4'hF,
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
